// File: rtl/dual_issue_scheduler_if.sv
// Fetch-buffer <-> issue-stage bundle: instruction window in, slide controls and issue ports out.
// master = fetch buffer side, slave = scheduler side.
interface dual_issue_scheduler_if;
  logic [31:0] instruction0;
  logic [31:0] instruction1;
  logic        nothing_filled;
  logic        branch_resolved;
  logic        freeze1;
  logic        freeze2;
  logic        dependency_on_ins2;
  logic        issue0_valid;
  logic [31:0] issue0_instr;
  logic        issue1_valid;
  logic [31:0] issue1_instr;

  modport master (
    output instruction0, instruction1, nothing_filled, branch_resolved,
    input  freeze1, freeze2, dependency_on_ins2,
    input  issue0_valid, issue0_instr, issue1_valid, issue1_instr
  );

  modport slave (
    input  instruction0, instruction1, nothing_filled, branch_resolved,
    output freeze1, freeze2, dependency_on_ins2,
    output issue0_valid, issue0_instr, issue1_valid, issue1_instr
  );
endinterface

// File: rtl/dual_issue_scheduler.sv
// Dual-issue stage: load scoreboard, intra-window dependency split, control-flow serialisation.
// Optional statistics counters built when SCHED_STATS_EN is defined.
module dual_issue_scheduler #(
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  dual_issue_scheduler_if.slave   bus,
  output logic [CNT_W-1:0]        stat_dual,
  output logic [CNT_W-1:0]        stat_single,
  output logic [CNT_W-1:0]        stat_stall
);

  localparam int unsigned NREG = 32;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       wr;
    logic       use1;
    logic       use2;
    logic       load;
    logic       mem;
    logic       ctrl;
  } dec_t;

  typedef enum logic {IDLE, CTRL_WAIT} state_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [6:0] op;
    op     = ins[6:0];
    d.rd   = ins[11:7];
    d.rs1  = ins[19:15];
    d.rs2  = ins[24:20];
    d.wr   = (op == OP_OP || op == OP_IMM || op == OP_LOAD || op == OP_LUI ||
              op == OP_AUIPC || op == OP_JAL || op == OP_JALR) && (ins[11:7] != 5'd0);
    d.use1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    d.use2 = (op == OP_OP || op == OP_STORE || op == OP_BRANCH);
    d.load = (op == OP_LOAD);
    d.mem  = (op == OP_LOAD || op == OP_STORE);
    d.ctrl = (op == OP_BRANCH || op == OP_JAL || op == OP_JALR);
    return d;
  endfunction

  state_t     state, state_nxt;
  logic [1:0] cnt [NREG];
  dec_t       d0, d1;
  logic       hz0, hz1, active;
  logic       raw, waw, ld_use;
  logic       f1, f2, dep, v0, v1;
  logic       ld_set;
  logic [4:0] ld_rd;

  assign d0 = decode(bus.instruction0);
  assign d1 = decode(bus.instruction1);

  // x0 counter is pinned at zero, so x0 sources never look hazardous
  assign hz0 = (d0.use1 && cnt[d0.rs1] != 2'd0) || (d0.use2 && cnt[d0.rs2] != 2'd0);
  assign hz1 = (d1.use1 && cnt[d1.rs1] != 2'd0) || (d1.use2 && cnt[d1.rs2] != 2'd0);

  assign raw    = d0.wr && ((d1.use1 && d1.rs1 == d0.rd) || (d1.use2 && d1.rs2 == d0.rd));
  assign waw    = d0.wr && d1.wr && (d0.rd == d1.rd);
  assign ld_use = d0.load && raw;

  // Issue decision and FSM next state
  always_comb begin
    state_nxt = state;
    f1        = 1'b0;
    f2        = 1'b0;
    dep       = 1'b0;
    v0        = 1'b0;
    v1        = 1'b0;
    active    = !rst && !bus.nothing_filled;
    f2        = (state == CTRL_WAIT);
    if (active) begin
      f1  = !f2 && hz0;
      v0  = !f1 && !f2;
      dep = v0 && ((bus.instruction1 == 32'd0) || hz1 || raw || waw ||
                   (d0.mem && d1.mem) || d0.ctrl || ld_use);
      v1  = v0 && !dep;
    end
    case (state)
      IDLE:      if ((v0 && d0.ctrl) || (v1 && d1.ctrl)) state_nxt = CTRL_WAIT;
      CTRL_WAIT: if (bus.branch_resolved) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign bus.freeze1            = f1;
  assign bus.freeze2            = f2;
  assign bus.dependency_on_ins2 = dep;
  assign bus.issue0_valid       = v0;
  assign bus.issue1_valid       = v1;
  assign bus.issue0_instr       = active ? bus.instruction0 : 32'd0;
  assign bus.issue1_instr       = active ? bus.instruction1 : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // At most one memory op issues per cycle, so at most one load sets a counter
  assign ld_set = (v0 && d0.load && d0.rd != 5'd0) || (v1 && d1.load && d1.rd != 5'd0);
  assign ld_rd  = (v0 && d0.load) ? d0.rd : d1.rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= 2'd0;
    end else begin
      cnt[0] <= 2'd0;
      for (int r = 1; r < NREG; r++) begin
        if (ld_set && ld_rd == 5'(r))  cnt[r] <= 2'(LOAD_LAT);
        else if (cnt[r] != 2'd0)       cnt[r] <= cnt[r] - 2'd1;
      end
    end
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_dual   <= '0;
      stat_single <= '0;
      stat_stall  <= '0;
    end else begin
      if (v1)              stat_dual   <= stat_dual + CNT_W'(1);
      if (v0 && !v1)       stat_single <= stat_single + CNT_W'(1);
      if (active && !v0)   stat_stall  <= stat_stall + CNT_W'(1);
    end
  end
`else
  assign stat_dual   = '0;
  assign stat_single = '0;
  assign stat_stall  = '0;
`endif

endmodule
